// File: rtl/mc_control_unit_pkg.sv
// Shared rv32i control definitions: opcodes, ALU operations, FSM states,
// datapath select encodings, trap causes and small funct3 decode helpers.
package mc_control_unit_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_R      = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  typedef enum logic {
    SRC_A_RS1 = 1'b0,
    SRC_A_PC  = 1'b1
  } src_a_t;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_IMM  = 2'd1,
    SRC_B_FOUR = 2'd2
  } src_b_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  typedef logic [2:0] mc_state_t;

  localparam mc_state_t ST_FETCH     = 3'd0;
  localparam mc_state_t ST_DECODE    = 3'd1;
  localparam mc_state_t ST_EXECUTE   = 3'd2;
  localparam mc_state_t ST_MEMORY    = 3'd3;
  localparam mc_state_t ST_WRITEBACK = 3'd4;
  localparam mc_state_t ST_TRAP      = 3'd5;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic is_legal_opcode(input opcode_t op);
    logic legal;
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
    return legal;
  endfunction

  // zero is the ALU result compare: SUB for equality, SLT/SLTU for ordering.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
    logic taken;
    case (f3)
      F3_BEQ, F3_BGE, F3_BGEU: taken = zero;
      F3_BNE, F3_BLT, F3_BLTU: taken = ~zero;
      default:                 taken = 1'b0;
    endcase
    return taken;
  endfunction

  function automatic logic [1:0] mem_size_of(input logic [2:0] f3);
    logic [1:0] size;
    case (f3)
      F3_LB, F3_LBU: size = MEM_BYTE;
      F3_LH, F3_LHU: size = MEM_HALF;
      F3_LW:         size = MEM_WORD;
      default:       size = MEM_WORD;
    endcase
    return size;
  endfunction

  function automatic logic mem_sign_of(input logic [2:0] f3);
    logic sign;
    case (f3)
      F3_LBU, F3_LHU: sign = 1'b0;
      default:        sign = 1'b1;
    endcase
    return sign;
  endfunction

endpackage

// File: rtl/mc_control_unit_alu_decode.sv
// Combinational funct3/funct7 to ALU operation decode for register,
// immediate, upper-immediate and branch-compare instructions.
module mc_alu_decode
  import mc_control_unit_pkg::*;
(
  input  opcode_t    opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_t    alu_op
);

  logic alt_s;
  logic unused_funct7_s;

  assign alt_s           = funct7[5];
  assign unused_funct7_s = ^{funct7[6], funct7[4:0]};

  // Immediate ADDI has no SUB form, so funct7 only qualifies SUB for R-type.
  always_comb begin
    alu_op = ALU_ADD;
    case (opcode)
      OP_R, OP_IMM: begin
        case (funct3)
          F3_ADD_SUB: alu_op = (opcode == OP_R && alt_s) ? ALU_SUB : ALU_ADD;
          F3_SLL:     alu_op = ALU_SLL;
          F3_SLT:     alu_op = ALU_SLT;
          F3_SLTU:    alu_op = ALU_SLTU;
          F3_XOR:     alu_op = ALU_XOR;
          F3_SRL_SRA: alu_op = alt_s ? ALU_SRA : ALU_SRL;
          F3_OR:      alu_op = ALU_OR;
          F3_AND:     alu_op = ALU_AND;
          default:    alu_op = ALU_ADD;
        endcase
      end
      OP_LUI:   alu_op = ALU_PASS_B;
      OP_AUIPC: alu_op = ALU_ADD;
      OP_BRANCH: begin
        case (funct3)
          F3_BEQ, F3_BNE:   alu_op = ALU_SUB;
          F3_BLT, F3_BGE:   alu_op = ALU_SLT;
          F3_BLTU, F3_BGEU: alu_op = ALU_SLTU;
          default:          alu_op = ALU_SUB;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle rv32i control FSM with variable-latency memory handshakes,
// illegal-opcode and data-bus-timeout traps.
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] TRAP_VEC    = 32'h0000_0100,
  parameter int unsigned           MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  opcode_t               opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  imem_ready,
  input  logic                  dmem_ready,
  output logic                  imem_req,
  output logic                  ir_we,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [1:0]            mem_size,
  output logic                  mem_sign,
  output src_a_t                alu_src_a,
  output src_b_t                alu_src_b,
  output alu_op_t               alu_op,
  output logic                  reg_we,
  output wb_sel_t               wb_sel,
  output logic                  pc_we,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output logic                  instr_retired,
  output mc_state_t             state
);

  localparam logic        TIMEOUT_EN   = (MEM_TIMEOUT != 0);
  localparam logic [15:0] TIMEOUT_LAST = (MEM_TIMEOUT == 0) ? 16'd0 : 16'(MEM_TIMEOUT - 1);

  mc_state_t             state_r;
  mc_state_t             state_nxt_s;
  logic                  active_r;
  logic [DATA_WIDTH-1:0] pc_plus4_r;
  logic [DATA_WIDTH-1:0] target_r;
  logic [DATA_WIDTH-1:0] next_pc_r;
  logic [DATA_WIDTH-1:0] npc_d_s;
  logic [15:0]           wait_cnt_r;
  logic [1:0]            cause_r;
  alu_op_t               dec_op_s;
  src_a_t                exec_a_s;
  src_b_t                exec_b_s;
  alu_op_t               exec_op_s;

  assign state = state_r;

  mc_alu_decode u_alu_decode (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .alu_op (dec_op_s)
  );

  // Operand selection held from EXECUTE through MEMORY/WRITEBACK so results stay stable.
  always_comb begin
    exec_a_s  = SRC_A_RS1;
    exec_b_s  = SRC_B_IMM;
    exec_op_s = ALU_ADD;
    case (opcode)
      OP_R, OP_BRANCH: begin
        exec_b_s  = SRC_B_RS2;
        exec_op_s = dec_op_s;
      end
      OP_IMM, OP_LUI: exec_op_s = dec_op_s;
      OP_AUIPC: begin
        exec_a_s  = SRC_A_PC;
        exec_op_s = dec_op_s;
      end
      OP_JAL: begin
        exec_a_s = SRC_A_PC;
        exec_b_s = SRC_B_FOUR;
      end
      default: exec_op_s = ALU_ADD;
    endcase
  end

  // FSM next state and control strobes; everything idles for one cycle after reset.
  always_comb begin
    state_nxt_s   = state_r;
    npc_d_s       = next_pc_r;
    imem_req      = 1'b0;
    ir_we         = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    mem_size      = MEM_WORD;
    mem_sign      = 1'b1;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_FOUR;
    alu_op        = ALU_ADD;
    reg_we        = 1'b0;
    wb_sel        = WB_ALU;
    pc_we         = 1'b0;
    next_pc       = next_pc_r;
    trap          = 1'b0;
    trap_cause    = CAUSE_NONE;
    if (active_r) begin
      case (state_r)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we       = 1'b1;
            npc_d_s     = alu_result;
            state_nxt_s = ST_DECODE;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end
        ST_DECODE: begin
          alu_src_b   = SRC_B_IMM;
          state_nxt_s = is_legal_opcode(opcode) ? ST_EXECUTE : ST_TRAP;
        end
        ST_EXECUTE: begin
          alu_src_a = exec_a_s;
          alu_src_b = exec_b_s;
          alu_op    = exec_op_s;
          case (opcode)
            OP_BRANCH: begin
              pc_we       = 1'b1;
              next_pc     = branch_taken(funct3, alu_result == '0)
                            ? {target_r[DATA_WIDTH-1:1], 1'b0} : pc_plus4_r;
              npc_d_s     = next_pc;
              state_nxt_s = ST_FETCH;
            end
            OP_LOAD, OP_STORE: state_nxt_s = ST_MEMORY;
            OP_JAL: begin
              npc_d_s     = {target_r[DATA_WIDTH-1:1], 1'b0};
              state_nxt_s = ST_WRITEBACK;
            end
            OP_JALR: begin
              npc_d_s     = {alu_result[DATA_WIDTH-1:1], 1'b0};
              state_nxt_s = ST_WRITEBACK;
            end
            default: state_nxt_s = ST_WRITEBACK;
          endcase
        end
        ST_MEMORY: begin
          alu_src_a = exec_a_s;
          alu_src_b = exec_b_s;
          alu_op    = exec_op_s;
          dmem_req  = 1'b1;
          dmem_we   = (opcode == OP_STORE);
          mem_size  = mem_size_of(funct3);
          mem_sign  = mem_sign_of(funct3);
          // A completing transfer beats a timeout expiring in the same cycle.
          if (dmem_ready) begin
            if (opcode == OP_STORE) begin
              pc_we       = 1'b1;
              state_nxt_s = ST_FETCH;
            end else begin
              state_nxt_s = ST_WRITEBACK;
            end
          end else if (TIMEOUT_EN && (wait_cnt_r == TIMEOUT_LAST)) begin
            state_nxt_s = ST_TRAP;
          end else begin
            state_nxt_s = ST_MEMORY;
          end
        end
        ST_WRITEBACK: begin
          alu_src_a   = exec_a_s;
          alu_src_b   = exec_b_s;
          alu_op      = exec_op_s;
          reg_we      = 1'b1;
          pc_we       = 1'b1;
          state_nxt_s = ST_FETCH;
          case (opcode)
            OP_LOAD:         wb_sel = WB_MEM;
            OP_JAL, OP_JALR: wb_sel = WB_PC4;
            default:         wb_sel = WB_ALU;
          endcase
        end
        ST_TRAP: begin
          trap        = 1'b1;
          trap_cause  = cause_r;
          pc_we       = 1'b1;
          next_pc     = TRAP_VEC;
          npc_d_s     = TRAP_VEC;
          state_nxt_s = ST_FETCH;
        end
        default: state_nxt_s = ST_FETCH;
      endcase
    end else begin
      state_nxt_s = ST_FETCH;
    end
    instr_retired = pc_we && (state_r != ST_TRAP);
  end

  // State, latched PC values, timeout counter and trap cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_FETCH;
      active_r   <= 1'b0;
      pc_plus4_r <= RESET_PC;
      target_r   <= RESET_PC;
      next_pc_r  <= RESET_PC;
      wait_cnt_r <= 16'd0;
      cause_r    <= CAUSE_NONE;
    end else begin
      state_r    <= state_nxt_s;
      active_r   <= 1'b1;
      next_pc_r  <= npc_d_s;
      wait_cnt_r <= (state_r == ST_MEMORY && !dmem_ready) ? wait_cnt_r + 16'd1 : 16'd0;
      if (ir_we) begin
        pc_plus4_r <= alu_result;
      end
      if (active_r && state_r == ST_DECODE) begin
        target_r <= alu_result;
      end
      if (state_nxt_s == ST_TRAP && state_r != ST_TRAP) begin
        cause_r <= (state_r == ST_DECODE) ? CAUSE_ILLEGAL : CAUSE_BUS;
      end
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: the bench plays IR and ALU, driving
// per-cycle opcode/alu_result/ready values and checking hand-computed strobes.
module tb_mc_control_unit;
  import mc_control_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  opcode_t     opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] alu_result;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        ir_we;
  logic        dmem_req;
  logic        dmem_we;
  logic [1:0]  mem_size;
  logic        mem_sign;
  src_a_t      alu_src_a;
  src_b_t      alu_src_b;
  alu_op_t     alu_op;
  logic        reg_we;
  wb_sel_t     wb_sel;
  logic        pc_we;
  logic [31:0] next_pc;
  logic        trap;
  logic [1:0]  trap_cause;
  logic        instr_retired;
  mc_state_t   state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] tbl_f3   [0:4] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b011};
  logic [1:0] tbl_size [0:4] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b10};
  logic       tbl_sign [0:4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  mc_control_unit #(
    .DATA_WIDTH  (32),
    .RESET_PC    (32'h0000_0000),
    .TRAP_VEC    (32'h0000_0100),
    .MEM_TIMEOUT (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .alu_result    (alu_result),
    .imem_ready    (imem_ready),
    .dmem_ready    (dmem_ready),
    .imem_req      (imem_req),
    .ir_we         (ir_we),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .mem_size      (mem_size),
    .mem_sign      (mem_sign),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .reg_we        (reg_we),
    .wb_sel        (wb_sel),
    .pc_we         (pc_we),
    .next_pc       (next_pc),
    .trap          (trap),
    .trap_cause    (trap_cause),
    .instr_retired (instr_retired),
    .state         (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // FETCH with immediate imem_ready, then DECODE; leaves the DUT entering EXECUTE.
  task automatic fetch_decode(input logic [31:0] pc4, input logic [31:0] tgt,
                              input opcode_t op, input logic [2:0] f3, input logic [6:0] f7);
    opcode     = op;
    funct3     = f3;
    funct7     = f7;
    dmem_ready = 1'b0;
    imem_ready = 1'b1;
    alu_result = pc4;
    #2;
    chk("fetch_state", state, ST_FETCH);
    chk("fetch_ir_we", ir_we, 1'b1);
    cyc();
    imem_ready = 1'b0;
    alu_result = tgt;
    #2;
    chk("decode_state", state, ST_DECODE);
    chk("decode_src_b", alu_src_b, SRC_B_IMM);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    opcode     = OP_IMM;
    funct3     = 3'b000;
    funct7     = 7'b0000000;
    alu_result = 32'h0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    cyc();
    cyc();
    #2;
    chk("rst_state", state, ST_FETCH);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_pc_we", pc_we, 1'b0);
    chk("rst_reg_we", reg_we, 1'b0);
    chk("rst_trap", trap, 1'b0);
    chk("rst_next_pc", next_pc, 32'h0);
    chk("rst_mem_size", mem_size, 2'b10);
    chk("rst_mem_sign", mem_sign, 1'b1);
    rst = 1'b0;
    cyc();

    // ADDI x1,x0,5 at PC 0
    fetch_decode(32'h4, 32'h5, OP_IMM, 3'b000, 7'b0000000);
    alu_result = 32'h5;
    #2;
    chk("addi_ex_op", alu_op, ALU_ADD);
    chk("addi_ex_srcb", alu_src_b, SRC_B_IMM);
    chk("addi_ex_reg_we", reg_we, 1'b0);
    cyc();
    #2;
    chk("addi_wb_state", state, ST_WRITEBACK);
    chk("addi_wb_reg_we", reg_we, 1'b1);
    chk("addi_wb_retire", instr_retired, 1'b1);
    chk("addi_wb_next_pc", next_pc, 32'h4);
    chk("addi_wb_sel", wb_sel, WB_ALU);
    cyc();
    #2;
    chk("addi_after_retire", instr_retired, 1'b0);
    chk("fetch_wait_req", imem_req, 1'b1);
    cyc();
    #2;
    chk("fetch_wait_hold", state, ST_FETCH);

    // SUB and SRA R-type decode
    fetch_decode(32'h8, 32'h99, OP_R, 3'b000, 7'b0100000);
    #2;
    chk("sub_op", alu_op, ALU_SUB);
    chk("sub_srcb", alu_src_b, SRC_B_RS2);
    chk("sub_srca", alu_src_a, SRC_A_RS1);
    cyc();
    cyc();
    fetch_decode(32'hC, 32'h99, OP_R, 3'b101, 7'b0100000);
    #2;
    chk("sra_op", alu_op, ALU_SRA);
    cyc();
    cyc();

    // BEQ at PC 0x20, imm 0x10: taken then not taken
    fetch_decode(32'h24, 32'h30, OP_BRANCH, 3'b000, 7'b0000000);
    alu_result = 32'h0;
    #2;
    chk("beq_t_op", alu_op, ALU_SUB);
    chk("beq_t_pc_we", pc_we, 1'b1);
    chk("beq_t_next_pc", next_pc, 32'h30);
    chk("beq_t_retire", instr_retired, 1'b1);
    cyc();
    #2;
    chk("beq_t_back_fetch", state, ST_FETCH);
    fetch_decode(32'h24, 32'h30, OP_BRANCH, 3'b000, 7'b0000000);
    alu_result = 32'h1;
    #2;
    chk("beq_nt_next_pc", next_pc, 32'h24);
    cyc();
    // BLT taken with an odd target, BGEU taken on zero compare
    fetch_decode(32'h34, 32'h41, OP_BRANCH, 3'b100, 7'b0000000);
    alu_result = 32'h1;
    #2;
    chk("blt_op", alu_op, ALU_SLT);
    chk("blt_next_pc", next_pc, 32'h40);
    cyc();
    fetch_decode(32'h44, 32'h60, OP_BRANCH, 3'b111, 7'b0000000);
    alu_result = 32'h0;
    #2;
    chk("bgeu_op", alu_op, ALU_SLTU);
    chk("bgeu_next_pc", next_pc, 32'h60);
    cyc();

    // LW with dmem_ready on the 4th MEMORY cycle
    fetch_decode(32'h64, 32'h200, OP_LOAD, 3'b010, 7'b0000000);
    alu_result = 32'h1000;
    #2;
    chk("lw_ex_srca", alu_src_a, SRC_A_RS1);
    chk("lw_ex_srcb", alu_src_b, SRC_B_IMM);
    cyc();
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3);
      #2;
      chk("lw_mem_req", dmem_req, 1'b1);
      chk("lw_mem_we", dmem_we, 1'b0);
      chk("lw_mem_size", mem_size, 2'b10);
      cyc();
    end
    dmem_ready = 1'b0;
    #2;
    chk("lw_wb_state", state, ST_WRITEBACK);
    chk("lw_wb_sel", wb_sel, WB_MEM);
    chk("lw_wb_retire", instr_retired, 1'b1);
    chk("lw_wb_next_pc", next_pc, 32'h64);
    cyc();

    // mem_size/mem_sign across load widths during MEMORY waits
    fetch_decode(32'h68, 32'h200, OP_LOAD, 3'b000, 7'b0000000);
    cyc();
    for (int i = 0; i < 5; i++) begin
      funct3     = tbl_f3[i];
      dmem_ready = (i == 4);
      #2;
      chk("ld_size", mem_size, tbl_size[i]);
      chk("ld_sign", mem_sign, tbl_sign[i]);
      cyc();
    end
    dmem_ready = 1'b0;
    cyc();

    // JAL to 0x80, JALR to 0x123 with bit 0 cleared
    fetch_decode(32'h6C, 32'h80, OP_JAL, 3'b000, 7'b0000000);
    #2;
    chk("jal_ex_pc_we", pc_we, 1'b0);
    cyc();
    #2;
    chk("jal_wb_sel", wb_sel, WB_PC4);
    chk("jal_wb_next_pc", next_pc, 32'h80);
    chk("jal_wb_reg_we", reg_we, 1'b1);
    cyc();
    fetch_decode(32'h84, 32'h999, OP_JALR, 3'b000, 7'b0000000);
    alu_result = 32'h123;
    #2;
    chk("jalr_ex_srca", alu_src_a, SRC_A_RS1);
    cyc();
    #2;
    chk("jalr_wb_next_pc", next_pc, 32'h122);
    chk("jalr_wb_sel", wb_sel, WB_PC4);
    cyc();

    // LUI and AUIPC operand selection
    fetch_decode(32'h88, 32'h999, OP_LUI, 3'b011, 7'b0000000);
    #2;
    chk("lui_op", alu_op, ALU_PASS_B);
    cyc();
    cyc();
    fetch_decode(32'h8C, 32'h999, OP_AUIPC, 3'b101, 7'b0100000);
    #2;
    chk("auipc_srca", alu_src_a, SRC_A_PC);
    chk("auipc_op", alu_op, ALU_ADD);
    cyc();
    cyc();

    // Illegal opcode 0 traps after DECODE
    fetch_decode(32'h90, 32'h999, opcode_t'(7'b0000000), 3'b000, 7'b0000000);
    #2;
    chk("ill_state", state, ST_TRAP);
    chk("ill_trap", trap, 1'b1);
    chk("ill_cause", trap_cause, 2'b01);
    chk("ill_next_pc", next_pc, 32'h100);
    chk("ill_reg_we", reg_we, 1'b0);
    chk("ill_retire", instr_retired, 1'b0);
    cyc();
    #2;
    chk("ill_trap_pulse", trap, 1'b0);
    chk("ill_hold_pc", next_pc, 32'h100);

    // SW never acknowledged: bus-timeout trap after 16 wait cycles
    fetch_decode(32'h104, 32'h999, OP_STORE, 3'b010, 7'b0000000);
    alu_result = 32'h2000;
    cyc();
    for (int i = 0; i < 16; i++) begin
      dmem_ready = 1'b0;
      #2;
      chk("sw_to_req", dmem_req, 1'b1);
      chk("sw_to_we", dmem_we, 1'b1);
      cyc();
    end
    #2;
    chk("sw_to_state", state, ST_TRAP);
    chk("sw_to_cause", trap_cause, 2'b10);
    chk("sw_to_next_pc", next_pc, 32'h100);
    chk("sw_to_retire", instr_retired, 1'b0);
    cyc();

    // SW acknowledged on the 16th MEMORY cycle completes normally
    fetch_decode(32'h104, 32'h999, OP_STORE, 3'b010, 7'b0000000);
    alu_result = 32'h2000;
    cyc();
    for (int i = 0; i < 15; i++) begin
      cyc();
    end
    dmem_ready = 1'b1;
    #2;
    chk("sw_rdy_trap", trap, 1'b0);
    chk("sw_rdy_pc_we", pc_we, 1'b1);
    chk("sw_rdy_retire", instr_retired, 1'b1);
    chk("sw_rdy_next_pc", next_pc, 32'h104);
    cyc();
    dmem_ready = 1'b0;
    #2;
    chk("sw_rdy_fetch", state, ST_FETCH);

    // Reset during a LOAD wait
    fetch_decode(32'h108, 32'h999, OP_LOAD, 3'b010, 7'b0000000);
    alu_result = 32'h3000;
    cyc();
    #2;
    chk("rld_req_before", dmem_req, 1'b1);
    rst = 1'b1;
    cyc();
    #2;
    chk("rld_state", state, ST_FETCH);
    chk("rld_dmem_req", dmem_req, 1'b0);
    chk("rld_next_pc", next_pc, 32'h0);
    chk("rld_imem_req", imem_req, 1'b0);
    rst = 1'b0;
    cyc();
    #2;
    chk("rld_restart_req", imem_req, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
